// File: rtl/mtr_drv_pkg.sv
// ---------------------------------------------------------------------------
// mtr_drv_pkg
//   Types and constants shared between the commutation block and the PWM
//   phase driver.
//
//   sel_t        per-phase drive mode coming from the commutation block
//   gate_pair_t  high/low gate pair for one phase
//   gate_map()   maps a phase mode and the PWM carrier to the desired gates
//   PWM_W        carrier / duty width (2048-clock period)
//   DUTY_CLAMP   largest duty loaded when PWM_DUTY_CLAMP_EN is defined
// ---------------------------------------------------------------------------
package mtr_drv_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] DUTY_CLAMP = 11'h7C0;

    typedef enum logic [1:0] {
        HIGHZ = 2'b00,
        REV   = 2'b01,
        FWD   = 2'b10,
        REGEN = 2'b11
    } sel_t;

    typedef struct packed {
        logic high;
        logic low;
    } gate_pair_t;

    // Desired gate state of one phase before dead-time insertion.
    function automatic gate_pair_t gate_map(input sel_t sel, input logic pwm);
        gate_pair_t g;
        g = '0;
        case (sel)
            HIGHZ: g = '0;
            REV: begin
                g.high = ~pwm;
                g.low  = pwm;
            end
            FWD: begin
                g.high = pwm;
                g.low  = ~pwm;
            end
            REGEN: begin
                g.high = 1'b0;
                g.low  = pwm;
            end
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/pwm_phase_drv_if.sv
// ---------------------------------------------------------------------------
// pwm_phase_drv_if
//   Bundle between the commutation block (master) and the PWM phase driver
//   (slave).
//
//   duty                    master->slave  11-bit duty, high clocks/period
//   selGrn/selYlw/selBlu    master->slave  per-phase mode (sel_t)
//   PWM_synch               slave->master  one-clock strobe per PWM period
//   high*/low*              slave->master  six gate drives
// ---------------------------------------------------------------------------
interface pwm_phase_drv_if;
    import mtr_drv_pkg::*;

    logic [PWM_W-1:0] duty;
    sel_t             selGrn;
    sel_t             selYlw;
    sel_t             selBlu;
    logic             PWM_synch;
    logic             highGrn;
    logic             lowGrn;
    logic             highYlw;
    logic             lowYlw;
    logic             highBlu;
    logic             lowBlu;

    modport master (
        output duty, selGrn, selYlw, selBlu,
        input  PWM_synch, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu
    );

    modport slave (
        input  duty, selGrn, selYlw, selBlu,
        output PWM_synch, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu
    );

endinterface

// File: rtl/pwm_phase_drv_nonoverlap.sv
// ---------------------------------------------------------------------------
// nonoverlap
//   Dead-time inserter for one half-bridge. Any change of the desired gate
//   pair holds both gates off for DEADTIME clocks; a change during dead time
//   restarts the full count. A desired 1/1 pair is never passed through.
//
//   Parameters: DEADTIME  dead-time in clocks, legal range 1..255
//   Ports:      clk, rst_n (async, active-low)
//               high_in/low_in    desired gate pair (combinational)
//               high_out/low_out  registered, dead-time-safe gate drives
//
//   Timing: turn-off 2 clocks after an input change, turn-on DEADTIME+2.
// ---------------------------------------------------------------------------
module nonoverlap #(
    parameter int DEADTIME = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic high_in,
    input  logic low_in,
    output logic high_out,
    output logic low_out
);

    localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME);

    logic [1:0] des_q, des_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] out_q, out_d;
    logic [7:0] dead_q, dead_d;
    logic       changed;

    always_comb begin
        des_d   = {high_in, low_in};
        prev_d  = des_q;
        changed = (des_q != prev_q);

        if (changed) begin
            dead_d = DEAD_LOAD;
        end else if (dead_q != 8'd0) begin
            dead_d = dead_q - 8'd1;
        end else begin
            dead_d = 8'd0;
        end

        // Outputs are released on the same edge the counter reaches zero,
        // which makes the both-off window exactly DEADTIME clocks long.
        if (dead_d != 8'd0 || des_q == 2'b11) begin
            out_d = 2'b00;
        end else begin
            out_d = des_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            des_q  <= 2'b00;
            prev_q <= 2'b00;
            out_q  <= 2'b00;
            dead_q <= 8'd0;
        end else begin
            des_q  <= des_d;
            prev_q <= prev_d;
            out_q  <= out_d;
            dead_q <= dead_d;
        end
    end

    assign high_out = out_q[1];
    assign low_out  = out_q[0];

endmodule

// File: rtl/pwm_phase_drv.sv
// ---------------------------------------------------------------------------
// pwm_phase_drv
//   PWM carrier and three-phase gate driver downstream of the commutation
//   block. A free-running 11-bit counter forms a 2048-clock carrier; duty is
//   shadowed once per period; each phase maps its mode and the PWM signal to
//   a desired gate pair that passes through a dead-time inserter.
//
//   Parameters: DEADTIME   dead-time in clocks (1..255)
//               SYNCH_CNT  carrier count that triggers PWM_synch
//   Ports:      clk        system clock
//               rst_n      asynchronous active-low reset
//               bus        pwm_phase_drv_if.slave: duty, selGrn/Ylw/Blu in;
//                          PWM_synch and the six gate drives out
//
//   Build option: PWM_DUTY_CLAMP_EN -- when defined, the shadowed duty is
//   limited to DUTY_CLAMP so the FWD low side always gets a bootstrap
//   refresh window each period.
// ---------------------------------------------------------------------------
module pwm_phase_drv
    import mtr_drv_pkg::*;
#(
    parameter int               DEADTIME  = 32,
    parameter logic [PWM_W-1:0] SYNCH_CNT = 11'h001
) (
    input logic             clk,
    input logic             rst_n,
    pwm_phase_drv_if.slave  bus
);

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    function automatic logic [PWM_W-1:0] clamp_duty(input logic [PWM_W-1:0] d);
`ifdef PWM_DUTY_CLAMP_EN
        return (d > DUTY_CLAMP) ? DUTY_CLAMP : d;
`else
        return d;
`endif
    endfunction

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             pwm_sig_q, pwm_sig_d;
    logic             synch_q, synch_d;

    gate_pair_t grn_des, ylw_des, blu_des;
    logic       grn_high, grn_low;
    logic       ylw_high, ylw_low;
    logic       blu_high, blu_low;

    // Carrier, duty shadow and strobe
    always_comb begin
        cnt_d = cnt_q + 11'd1;
        // Loading only on the last count keeps every period at one duty.
        duty_d    = (cnt_q == CNT_MAX) ? clamp_duty(bus.duty) : duty_q;
        pwm_sig_d = (cnt_q < duty_q);
        synch_d   = (cnt_q == SYNCH_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            duty_q    <= '0;
            pwm_sig_q <= 1'b0;
            synch_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            pwm_sig_q <= pwm_sig_d;
            synch_q   <= synch_d;
        end
    end

    // Desired gate pairs per phase
    assign grn_des = gate_map(bus.selGrn, pwm_sig_q);
    assign ylw_des = gate_map(bus.selYlw, pwm_sig_q);
    assign blu_des = gate_map(bus.selBlu, pwm_sig_q);

    // Dead-time insertion per phase
    nonoverlap #(.DEADTIME(DEADTIME)) u_no_grn (
        .clk      (clk),
        .rst_n    (rst_n),
        .high_in  (grn_des.high),
        .low_in   (grn_des.low),
        .high_out (grn_high),
        .low_out  (grn_low)
    );

    nonoverlap #(.DEADTIME(DEADTIME)) u_no_ylw (
        .clk      (clk),
        .rst_n    (rst_n),
        .high_in  (ylw_des.high),
        .low_in   (ylw_des.low),
        .high_out (ylw_high),
        .low_out  (ylw_low)
    );

    nonoverlap #(.DEADTIME(DEADTIME)) u_no_blu (
        .clk      (clk),
        .rst_n    (rst_n),
        .high_in  (blu_des.high),
        .low_in   (blu_des.low),
        .high_out (blu_high),
        .low_out  (blu_low)
    );

    assign bus.PWM_synch = synch_q;
    assign bus.highGrn   = grn_high;
    assign bus.lowGrn    = grn_low;
    assign bus.highYlw   = ylw_high;
    assign bus.lowYlw    = ylw_low;
    assign bus.highBlu   = blu_high;
    assign bus.lowBlu    = blu_low;

endmodule

// File: tb/tb_pwm_phase_drv.sv
// ---------------------------------------------------------------------------
// tb_pwm_phase_drv
//   Self-checking bench for pwm_phase_drv. Expected values are queued when
//   stimulus is applied and compared when the corresponding DUT behaviour is
//   observed. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pwm_phase_drv;
    import mtr_drv_pkg::*;

    localparam int DT = 32;
`ifdef PWM_DUTY_CLAMP_EN
    localparam int EXP_MAX_W = 1984 - DT;
`else
    localparam int EXP_MAX_W = 2047 - DT;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    int overlap_viol = 0;
    int hi_samples   = 0;
    int blu_samples  = 0;
    int any_samples  = 0;

    pwm_phase_drv_if bus();

    pwm_phase_drv #(.DEADTIME(DT), .SYNCH_CNT(11'h001)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((bus.highGrn & bus.lowGrn) | (bus.highYlw & bus.lowYlw) | (bus.highBlu & bus.lowBlu))
            overlap_viol <= overlap_viol + 1;
        if (bus.highGrn | bus.highYlw | bus.highBlu)
            hi_samples <= hi_samples + 1;
        if (bus.highBlu | bus.lowBlu)
            blu_samples <= blu_samples + 1;
        if (bus.highGrn | bus.lowGrn | bus.highYlw | bus.lowYlw | bus.highBlu | bus.lowBlu)
            any_samples <= any_samples + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] gates();
        return {bus.highGrn, bus.lowGrn, bus.highYlw, bus.lowYlw, bus.highBlu, bus.lowBlu};
    endfunction

    function automatic logic gate_at(input int idx);
        logic [5:0] g;
        g = gates();
        return g[5-idx];
    endfunction

    task automatic wait_synch(output int n);
        n = -1;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            if (bus.PWM_synch === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_until(input int idx, input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (gate_at(idx) === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Width in clocks of the next complete high pulse on gate idx; -1 on timeout.
    task automatic measure_pulse(input int idx, output int width);
        bit seen_low;
        bit rose;
        seen_low = 1'b0;
        rose     = 1'b0;
        width    = -1;
        for (int i = 0; i < 4300; i++) begin
            @(negedge clk);
            if (gate_at(idx) !== 1'b1) seen_low = 1'b1;
            else if (seen_low) begin
                rose = 1'b1;
                break;
            end
        end
        if (!rose) return;
        width = 1;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (gate_at(idx) !== 1'b1) return;
            width++;
        end
        width = -1;
    endtask

    task automatic test_reset();
        logic [5:0] g;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        g = gates();
        checks++;
        if (g !== 6'b0) begin
            errors++;
            $display("FAIL reset_gates got %b expected %b", g, 6'b0);
        end
        checks++;
        if (bus.PWM_synch !== 1'b0) begin
            errors++;
            $display("FAIL reset_synch got %b expected 0", bus.PWM_synch);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_synch();
        int n, e, a0;
        a0 = any_samples;
        exp_q.push_back(2);
        exp_q.push_back(2048);
        exp_q.push_back(0);
        wait_synch(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL synch_first got %0d expected %0d", n, e);
        end
        wait_synch(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL synch_period got %0d expected %0d", n, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (any_samples - a0 !== e) begin
            errors++;
            $display("FAIL highz_gates got %0d expected %0d", any_samples - a0, e);
        end
    endtask

    task automatic test_fwd();
        int w, e;
        bus.duty   = 11'h400;
        bus.selGrn = FWD;
        exp_q.push_back(1024 - DT);
        exp_q.push_back(DT);
        exp_q.push_back(2048 - 1024 - DT);
        exp_q.push_back(DT);
        measure_pulse(0, w);
        e = exp_q.pop_front();
        checks++;
        if (w !== e) begin
            errors++;
            $display("FAIL fwd_high_width got %0d expected %0d", w, e);
        end
        count_until(1, 1'b1, 200, w);
        e = exp_q.pop_front();
        checks++;
        if (w !== e) begin
            errors++;
            $display("FAIL fwd_dead_hl got %0d expected %0d", w, e);
        end
        count_until(1, 1'b0, 2100, w);
        e = exp_q.pop_front();
        checks++;
        if (w !== e) begin
            errors++;
            $display("FAIL fwd_low_width got %0d expected %0d", w, e);
        end
        count_until(0, 1'b1, 200, w);
        e = exp_q.pop_front();
        checks++;
        if (w !== e) begin
            errors++;
            $display("FAIL fwd_dead_lh got %0d expected %0d", w, e);
        end
    endtask

    task automatic test_duty_change();
        int n, w, e;
        wait_synch(n);
        // At this sample the carrier count is 2; change duty at count 500.
        fork
            begin
                repeat (498) @(negedge clk);
                bus.duty = 11'h600;
            end
        join_none
        exp_q.push_back(1024 - DT);
        exp_q.push_back(1536 - DT);
        measure_pulse(0, w);
        e = exp_q.pop_front();
        checks++;
        if (w !== e) begin
            errors++;
            $display("FAIL duty_chg_cur got %0d expected %0d", w, e);
        end
        measure_pulse(0, w);
        e = exp_q.pop_front();
        checks++;
        if (w !== e) begin
            errors++;
            $display("FAIL duty_chg_next got %0d expected %0d", w, e);
        end
    endtask

    task automatic test_rev_switch();
        int n, e;
        bus.selYlw = FWD;
        count_until(2, 1'b1, 2200, n);
        repeat (100) @(negedge clk);
        bus.selYlw = REV;
        exp_q.push_back(2);
        exp_q.push_back(DT);
        count_until(2, 1'b0, 10, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL rev_turnoff got %0d expected %0d", n, e);
        end
        count_until(3, 1'b1, 100, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL rev_dead got %0d expected %0d", n, e);
        end
    endtask

    task automatic test_toggle();
        int n, e, b0;
        logic [1:0] pair;
        wait_synch(n);
        repeat (98) @(negedge clk);
        b0 = blu_samples;
        for (int i = 0; i < 8; i++) begin
            bus.selBlu = (i % 2 == 0) ? FWD : REV;
            if (i < 7) repeat (10) @(negedge clk);
        end
        exp_q.push_back(0);
        exp_q.push_back(DT + 2);
        exp_q.push_back(2'b01);
        e = exp_q.pop_front();
        checks++;
        if (blu_samples - b0 !== e) begin
            errors++;
            $display("FAIL toggle_quiet got %0d expected %0d", blu_samples - b0, e);
        end
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.highBlu === 1'b1 || bus.lowBlu === 1'b1) begin
                n = i;
                break;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL toggle_release got %0d expected %0d", n, e);
        end
        pair = {bus.highBlu, bus.lowBlu};
        e = exp_q.pop_front();
        checks++;
        if (pair !== e[1:0]) begin
            errors++;
            $display("FAIL toggle_pair got %b expected %b", pair, e[1:0]);
        end
    endtask

    task automatic test_regen();
        int n, w, e, h0;
        wait_synch(n);
        repeat (598) @(negedge clk);
        bus.selGrn = REGEN;
        bus.selYlw = REGEN;
        bus.selBlu = REGEN;
        wait_synch(n);
        h0 = hi_samples;
        for (int k = 0; k < 3; k++) exp_q.push_back(1536 - DT);
        exp_q.push_back(0);
        for (int k = 0; k < 3; k++) begin
            measure_pulse(2 * k + 1, w);
            e = exp_q.pop_front();
            checks++;
            if (w !== e) begin
                errors++;
                $display("FAIL regen_low_width phase %0d got %0d expected %0d", k, w, e);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (hi_samples - h0 !== e) begin
            errors++;
            $display("FAIL regen_high_off got %0d expected %0d", hi_samples - h0, e);
        end
    endtask

    task automatic test_duty_max();
        int n, w, e;
        bus.duty = 11'h7FF;
        wait_synch(n);
        wait_synch(n);
        exp_q.push_back(EXP_MAX_W);
        measure_pulse(1, w);
        e = exp_q.pop_front();
        checks++;
        if (w !== e) begin
            errors++;
            $display("FAIL duty_max_width got %0d expected %0d", w, e);
        end
    endtask

    task automatic test_reset_mid();
        int e, fs, rise;
        logic [5:0] g;
        repeat (300) @(negedge clk);
        exp_q.push_back(1);
        e = exp_q.pop_front();
        checks++;
        if (bus.lowGrn !== e[0]) begin
            errors++;
            $display("FAIL pre_reset_low got %b expected %b", bus.lowGrn, e[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        g = gates();
        checks++;
        if (g !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_gates got %b expected %b", g, 6'b0);
        end
        checks++;
        if (bus.PWM_synch !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_synch got %b expected 0", bus.PWM_synch);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(2048 + 1 + DT + 2);
        fs   = -1;
        rise = -1;
        for (int i = 1; i <= 2200; i++) begin
            @(negedge clk);
            if (bus.PWM_synch === 1'b1 && fs < 0) fs = i;
            if (bus.lowGrn === 1'b1) begin
                rise = i;
                break;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (fs !== e) begin
            errors++;
            $display("FAIL rst_first_synch got %0d expected %0d", fs, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (rise !== e) begin
            errors++;
            $display("FAIL rst_first_gate got %0d expected %0d", rise, e);
        end
    endtask

    task automatic test_invariant();
        checks++;
        if (overlap_viol !== 0) begin
            errors++;
            $display("FAIL shoot_through got %0d samples expected 0", overlap_viol);
        end
    endtask

    initial begin
        bus.duty   = 11'h000;
        bus.selGrn = HIGHZ;
        bus.selYlw = HIGHZ;
        bus.selBlu = HIGHZ;
        test_reset();
        test_synch();
        test_fwd();
        test_duty_change();
        test_rev_switch();
        test_toggle();
        test_regen();
        test_duty_max();
        test_reset_mid();
        test_invariant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
